// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge transfer path:
// FSM states, slave address regions, one-hot selects and the request entry.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_t;

  localparam logic [5:0] REGION_S0 = 6'b100000;
  localparam logic [5:0] REGION_S1 = 6'b100001;
  localparam logic [5:0] REGION_S2 = 6'b100010;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_req_t;

  // Returns PSEL_NONE for an address outside every slave region.
  function automatic logic [2:0] decode_psel(input logic [31:0] addr);
    case (addr[31:26])
      REGION_S0: return PSEL_S0;
      REGION_S1: return PSEL_S1;
      REGION_S2: return PSEL_S2;
      default:   return PSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Request buffer: DEPTH-entry synchronous FIFO with combinational head output
// and full/empty flags. Pushes while full and pops while empty are ignored.
module apb_req_fifo
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  logic     i_pop,
  input  apb_req_t i_data,
  output apb_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  apb_req_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_transfer_controller.sv
// APB master sequencer: buffers bridge requests, decodes the slave select and
// runs SETUP/ACCESS with wait states and timeout, returning a one-cycle response.
module apb_transfer_controller
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready
);

  localparam int unsigned        WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]      WAIT_LAST = WW'(TIMEOUT - 1);

  apb_state_t    r_state;
  logic [WW-1:0] r_wait;
  apb_req_t      w_in;
  apb_req_t      w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_done;
  logic          w_pop;
  logic [2:0]    w_sel;

  assign w_in      = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !w_full;
  assign w_sel     = decode_psel(w_head.addr);
  assign w_done    = (r_state == ACCESS) && (Pready || (r_wait == WAIT_LAST));
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_done);

  apb_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (Hclk),
    .i_rst  (Hreset),
    .i_push (req_valid),
    .i_pop  (w_pop),
    .i_data (w_in),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (r_state)
        IDLE: ;
        SETUP: begin
          Penable <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (w_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !Pready;
            rsp_rdata <= (Pready && !Pwrite) ? Prdata : '0;
            r_state   <= IDLE;
            Pselx     <= '0;
            Penable   <= 1'b0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A pop (from IDLE or a finishing ACCESS) overrides the idle exit above.
      if (w_pop) begin
        Penable <= 1'b0;
        r_wait  <= '0;
        if (w_sel != PSEL_NONE) begin
          r_state <= SETUP;
          Pselx   <= w_sel;
          Paddr   <= w_head.addr;
          Pwrite  <= w_head.write;
          Pwdata  <= w_head.wdata;
        end else begin
          r_state <= ERR;
          Pselx   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_transfer_controller.sv
// Directed self-checking bench for apb_transfer_controller (DEPTH=2, TIMEOUT=16).
module tb_apb_transfer_controller;

  logic        Hclk;
  logic        Hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;

  int n_pass  = 0;
  int n_total = 0;
  int rsp_cnt = 0;

  apb_transfer_controller #(
    .DEPTH  (2),
    .TIMEOUT(16)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .Pwrite   (Pwrite),
    .Penable  (Penable),
    .Pselx    (Pselx),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .Pready   (Pready)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  always @(negedge Hclk) if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (Pselx !== 3'b000) $display("FAIL reset_psel got=%b exp=000", Pselx); else n_pass++;
    n_total++; if (Penable !== 1'b0) $display("FAIL reset_penable got=%b exp=0", Penable); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_total++; if ({Pwrite, Paddr, Pwdata} !== 65'd0) $display("FAIL reset_apb got=%b/%h/%h exp=0/0/0", Pwrite, Paddr, Pwdata); else n_pass++;
    tick();
    tick();
    Hreset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    Pready = 1'b1;
    Prdata = 32'h0000_0019;
    offer(1'b0, 32'h8000_0010, 32'h0);
    tick();
    req_valid = 1'b0;
    n_total++; if (Pselx !== 3'b000) $display("FAIL rd_c1_psel got=%b exp=000", Pselx); else n_pass++;
    tick();
    n_total++; if ({Pselx, Penable} !== 4'b0010) $display("FAIL rd_setup got=%b/%b exp=001/0", Pselx, Penable); else n_pass++;
    n_total++; if ({Pwrite, Paddr} !== {1'b0, 32'h8000_0010}) $display("FAIL rd_setup_addr got=%b/%h exp=0/80000010", Pwrite, Paddr); else n_pass++;
    tick();
    n_total++; if ({Pselx, Penable, rsp_valid} !== 5'b00110) $display("FAIL rd_access got=%b/%b/%b exp=001/1/0", Pselx, Penable, rsp_valid); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h19}) $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/00000019", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_total++; if ({Pselx, Penable} !== 4'b0000) $display("FAIL rd_idle got=%b/%b exp=000/0", Pselx, Penable); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rd_pulse got=%b exp=0", rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    Pready = 1'b1;
    Prdata = 32'hFFFF_0000;
    offer(1'b1, 32'h8400_0000, 32'hA5A5_A5A5);
    tick();
    offer(1'b1, 32'h8800_0004, 32'h5A5A_5A5A);
    tick();
    req_valid = 1'b0;
    n_total++; if ({Pselx, Penable, Pwrite} !== 5'b01001) $display("FAIL b2b_setup1 got=%b/%b/%b exp=010/0/1", Pselx, Penable, Pwrite); else n_pass++;
    n_total++; if ({Paddr, Pwdata} !== {32'h8400_0000, 32'hA5A5_A5A5}) $display("FAIL b2b_data1 got=%h/%h exp=84000000/a5a5a5a5", Paddr, Pwdata); else n_pass++;
    tick();
    n_total++; if ({Pselx, Penable} !== 4'b0101) $display("FAIL b2b_access1 got=%b/%b exp=010/1", Pselx, Penable); else n_pass++;
    tick();
    n_total++; if ({Pselx, Penable} !== 4'b1000) $display("FAIL b2b_setup2 got=%b/%b exp=100/0", Pselx, Penable); else n_pass++;
    n_total++; if ({Paddr, Pwdata} !== {32'h8800_0004, 32'h5A5A_5A5A}) $display("FAIL b2b_data2 got=%h/%h exp=88000004/5a5a5a5a", Paddr, Pwdata); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) $display("FAIL b2b_rsp1 got=%b/%b/%h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    tick();
    n_total++; if ({Penable, rsp_valid} !== 2'b10) $display("FAIL b2b_access2 got=%b/%b exp=1/0", Penable, rsp_valid); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata, Pselx} !== {2'b10, 32'h0, 3'b000}) $display("FAIL b2b_rsp2 got=%b/%b/%h/%b exp=1/0/0/000", rsp_valid, rsp_err, rsp_rdata, Pselx); else n_pass++;
    tick();
  endtask

  task automatic test_wait_states();
    int bad = 0;
    Pready = 1'b0;
    Prdata = 32'h0000_1234;
    offer(1'b0, 32'h8000_0020, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Penable !== 1'b1 || Pselx !== 3'b001 || Paddr !== 32'h8000_0020 || Pwrite !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL wait_stable got=%0d unstable cycles exp=0", bad); else n_pass++;
    Pready = 1'b1;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234}) $display("FAIL wait_rsp got=%b/%b/%h exp=1/0/00001234", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wait_pulse got=%b exp=0", rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    Pready = 1'b0;
    Prdata = 32'hDEAD_BEEF;
    offer(1'b0, 32'h8000_0030, 32'h0);
    tick();
    offer(1'b1, 32'h8400_0008, 32'h1122_3344);
    tick();
    req_valid = 1'b0;
    n_total++; if ({Pselx, Penable} !== 4'b0010) $display("FAIL to_setup got=%b/%b exp=001/0", Pselx, Penable); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (Penable !== 1'b1 || Pselx !== 3'b001 || rsp_valid !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL to_access16 got=%0d bad cycles exp=0", bad); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) $display("FAIL to_rsp got=%b/%b/%h exp=1/1/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_total++; if ({Pselx, Penable, Pwrite} !== 5'b01001) $display("FAIL to_next_setup got=%b/%b/%b exp=010/0/1", Pselx, Penable, Pwrite); else n_pass++;
    Pready = 1'b1;
    tick();
    n_total++; if ({Penable, rsp_valid} !== 2'b10) $display("FAIL to_next_access got=%b/%b exp=1/0", Penable, rsp_valid); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) $display("FAIL to_next_rsp got=%b/%b/%h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_full_and_miss();
    Pready = 1'b0;
    Prdata = 32'h0000_0077;
    offer(1'b0, 32'h8000_0040, 32'h0);
    tick();
    offer(1'b0, 32'h0000_1000, 32'h0);
    tick();
    n_total++; if (req_ready !== 1'b1) $display("FAIL fm_ready_c2 got=%b exp=1", req_ready); else n_pass++;
    offer(1'b1, 32'h8800_0010, 32'hCAFE_F00D);
    tick();
    offer(1'b0, 32'h8000_0050, 32'h0);
    n_total++; if (req_ready !== 1'b0) $display("FAIL fm_full_c3 got=%b exp=0", req_ready); else n_pass++;
    tick();
    n_total++; if (req_ready !== 1'b0) $display("FAIL fm_full_c4 got=%b exp=0", req_ready); else n_pass++;
    Pready = 1'b1;
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h77}) $display("FAIL fm_rsp_a got=%b/%b/%h exp=1/0/00000077", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_total++; if ({Pselx, Penable, req_ready} !== 5'b00001) $display("FAIL fm_err_state got=%b/%b/%b exp=000/0/1", Pselx, Penable, req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) $display("FAIL fm_rsp_miss got=%b/%b/%h exp=1/1/0", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    n_total++; if ({Pselx, Penable} !== 4'b0000) $display("FAIL fm_miss_idle got=%b/%b exp=000/0", Pselx, Penable); else n_pass++;
    tick();
    n_total++; if ({Pselx, Pwrite, Paddr} !== {3'b100, 1'b1, 32'h8800_0010}) $display("FAIL fm_setup_c got=%b/%b/%h exp=100/1/88000010", Pselx, Pwrite, Paddr); else n_pass++;
    tick();
    tick();
    n_total++; if ({rsp_valid, rsp_err, Pselx, Paddr} !== {2'b10, 3'b001, 32'h8000_0050}) $display("FAIL fm_rsp_c got=%b/%b/%b/%h exp=1/0/001/80000050", rsp_valid, rsp_err, Pselx, Paddr); else n_pass++;
    tick();
    tick();
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h77}) $display("FAIL fm_rsp_d got=%b/%b/%h exp=1/0/00000077", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_response_count();
    n_total++; if (rsp_cnt !== 10) $display("FAIL rsp_count got=%0d exp=10", rsp_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    Pready = 1'b0;
    offer(1'b0, 32'h8000_0060, 32'h0);
    tick();
    offer(1'b1, 32'h8400_0000, 32'h0000_00AA);
    tick();
    req_valid = 1'b0;
    tick();
    n_total++; if (Penable !== 1'b1) $display("FAIL rm_in_access got=%b exp=1", Penable); else n_pass++;
    base = rsp_cnt;
    #2 Hreset = 1'b1;
    #1;
    n_total++; if ({Pselx, Penable, req_ready} !== 5'b00001) $display("FAIL rm_async got=%b/%b/%b exp=000/0/1", Pselx, Penable, req_ready); else n_pass++;
    n_total++; if (Paddr !== 32'h0) $display("FAIL rm_paddr got=%h exp=0", Paddr); else n_pass++;
    tick();
    Hreset = 1'b0;
    Pready = 1'b1;
    repeat (6) tick();
    n_total++; if (rsp_cnt !== base) $display("FAIL rm_no_rsp got=%0d exp=%0d", rsp_cnt, base); else n_pass++;
    n_total++; if (Pselx !== 3'b000) $display("FAIL rm_flushed got=%b exp=000", Pselx); else n_pass++;
  endtask

  initial begin
    Hreset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    Prdata    = '0;
    Pready    = 1'b1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_full_and_miss();
    test_response_count();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
